// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder fronting a byte-addressed RAM.
// Opcode 0x02 writes a burst and opcode 0x03 reads a burst. Each is followed by a
// 24-bit address, MSB first. All SPI inputs are oversampled on clk. The pointer
// wraps at 2^ADDR_W.
module spi_ram_responder #(
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic css,
    input  logic sdi,
    output logic sdo,
    output logic frame_done,
    output logic cmd_err
);

    localparam int DEPTH = 1 << ADDR_W;
    // The shift register keeps only the bits that are still needed once the
    // current sdi is appended: 7 bits for a byte, or ADDR_W-1 bits for the pointer.
    localparam int SH_W  = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] css_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sck_prev_q;
    logic                   css_prev_q;
    logic                   sck_s;
    logic                   css_s;
    logic                   sdi_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   css_rise;
    logic                   css_fall;

    state_t                 state_q;
    logic [4:0]             bit_cnt_q;
    logic [SH_W-1:0]        shift_q;
    logic [SH_W-1:0]        shift_d;
    logic [7:0]             rx_byte;
    logic                   rd_op_q;
    logic [ADDR_W-1:0]      ptr_q;
    logic [6:0]             tx_q;
    logic                   sdo_q;
    logic                   frame_done_q;
    logic                   cmd_err_q;

    logic [7:0]             mem [DEPTH];
    logic [7:0]             rd_byte;
    logic                   mem_we;

    // Synchronize the SPI inputs and keep the previous values for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            css_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            css_prev_q <= 1'b0;
        end else begin
            sck_sync_q[0] <= sck;
            css_sync_q[0] <= css;
            sdi_sync_q[0] <= sdi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_q[i] <= sck_sync_q[i-1];
                css_sync_q[i] <= css_sync_q[i-1];
                sdi_sync_q[i] <= sdi_sync_q[i-1];
            end
            sck_prev_q <= sck_s;
            css_prev_q <= css_s;
        end
    end

    // Edge strobes, assembled serial words and the memory write strobe
    always_comb begin
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        css_s    = css_sync_q[SYNC_STAGES-1];
        sdi_s    = sdi_sync_q[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_prev_q;
        sck_fall = ~sck_s & sck_prev_q;
        css_rise = css_s & ~css_prev_q;
        css_fall = ~css_s & css_prev_q;
        shift_d  = {shift_q[SH_W-2:0], sdi_s};
        rx_byte  = {shift_q[6:0], sdi_s};
        rd_byte  = mem[ptr_q];
        // A css rise in the same clk aborts the frame, so the partial byte is never written
        mem_we   = ~rst && (state_q == S_WDATA) && sck_rise && ~css_rise && (bit_cnt_q == 5'd7);
    end

    // Byte memory; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= rx_byte;
        end
    end

    // Frame state machine with registered sdo and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rd_op_q      <= 1'b0;
            ptr_q        <= '0;
            tx_q         <= '0;
            sdo_q        <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            if (sck_rise) begin
                shift_q <= shift_d;
            end
            if (css_rise && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                bit_cnt_q    <= '0;
                sdo_q        <= 1'b0;
                frame_done_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        sdo_q <= 1'b0;
                        if (css_fall) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                if (rx_byte == 8'h02 || rx_byte == 8'h03) begin
                                    rd_op_q <= (rx_byte == 8'h03);
                                    state_q <= S_ADDR;
                                end else begin
                                    cmd_err_q <= 1'b1;
                                    state_q   <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q <= '0;
                                ptr_q     <= {shift_q[ADDR_W-2:0], sdi_s};
                                state_q   <= rd_op_q ? S_RDATA : S_WDATA;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sck_rise) begin
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                ptr_q     <= ptr_q + ADDR_W'(1);
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        // bit_cnt counts the bits already presented from the current byte.
                        // A count of 0 (first fall) or 8 (byte exhausted) fetches the next byte.
                        if (sck_fall) begin
                            if (bit_cnt_q == 5'd0 || bit_cnt_q == 5'd8) begin
                                sdo_q     <= rd_byte[7];
                                tx_q      <= rd_byte[6:0];
                                ptr_q     <= ptr_q + ADDR_W'(1);
                                bit_cnt_q <= 5'd1;
                            end else begin
                                sdo_q     <= tx_q[6];
                                tx_q      <= {tx_q[5:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        sdo_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        sdo_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sdo        = sdo_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder. It drives SPI mode-0 frames and
// compares the results against a plain byte-array model of the RAM.
module tb_spi_ram_responder;

    localparam int AW    = 12;
    localparam int MEMSZ = 1 << AW;
    localparam int H     = 5;  // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic css = 1'b1;
    logic sdi = 1'b0;
    logic sdo;
    logic frame_done;
    logic cmd_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ce_cnt = 0;

    logic [7:0] mdl    [MEMSZ];
    bit         mvalid [MEMSZ];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    spi_ram_responder #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .css        (css),
        .sdi        (sdi),
        .sdo        (sdo),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (cmd_err === 1'b1) ce_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        css = 1'b0;
        clk_n(H);
    endtask

    task automatic spi_end();
        clk_n(H);
        css = 1'b1;
        clk_n(2 * H);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        sdi = b;
        clk_n(H);
        sck = 1'b1;
        r = sdo;
        clk_n(H);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], x);
            r[i] = x;
        end
    endtask

    task automatic spi_header(input logic [7:0] op, input logic [23:0] addr, output logic [7:0] sdo_or);
        logic [7:0] r;
        spi_byte(op, r);           sdo_or = r;
        spi_byte(addr[23:16], r);  sdo_or |= r;
        spi_byte(addr[15:8], r);   sdo_or |= r;
        spi_byte(addr[7:0], r);    sdo_or |= r;
    endtask

    // Write txq[0..n-1] starting at addr and update the reference model
    task automatic do_write(input logic [23:0] addr, input int n, output logic [7:0] sdo_or);
        logic [7:0] r;
        int base;
        base = int'(addr) % MEMSZ;
        spi_begin();
        spi_header(8'h02, addr, sdo_or);
        for (int i = 0; i < n; i++) begin
            spi_byte(txq[i], r);
            sdo_or |= r;
            mdl[(base + i) % MEMSZ] = txq[i];
            mvalid[(base + i) % MEMSZ] = 1'b1;
        end
        spi_end();
    endtask

    // Read n bytes from addr into rxq
    task automatic do_read(input logic [23:0] addr, input int n, output logic [7:0] sdo_or);
        logic [7:0] r;
        rxq.delete();
        spi_begin();
        spi_header(8'h03, addr, sdo_or);
        for (int i = 0; i < n; i++) begin
            spi_byte($urandom_range(0, 255), r);
            rxq.push_back(r);
        end
        spi_end();
    endtask

    task automatic test_reset();
        logic [7:0] r;
        int fd0, ce0;
        css = 1'b0;
        rst = 1'b1;
        clk_n(4);
        checks++;
        if (sdo !== 1'b0 || frame_done !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: sdo=%b frame_done=%b cmd_err=%b, required 0 0 0", sdo, frame_done, cmd_err);
        end
        fd0 = fd_cnt;
        ce0 = ce_cnt;
        rst = 1'b0;
        clk_n(H);
        // css was already low at reset release, so this byte must not start a frame
        spi_byte(8'h05, r);
        clk_n(H);
        css = 1'b1;
        clk_n(2 * H);
        checks++;
        if (ce_cnt - ce0 !== 0 || fd_cnt - fd0 !== 0) begin
            errors++;
            $display("FAIL css_low_at_release: cmd_err pulses=%0d frame_done pulses=%0d, required 0 0", ce_cnt - ce0, fd_cnt - fd0);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] o;
        int fd0;
        fd0 = fd_cnt;
        txq = '{8'hA5, 8'h3C};
        do_write(24'h000010, 2, o);
        do_read(24'h000010, 2, o);
        checks++;
        if (rxq[0] !== 8'hA5 || rxq[1] !== 8'h3C) begin
            errors++;
            $display("FAIL write_read: got %h %h, required a5 3c", rxq[0], rxq[1]);
        end
        checks++;
        if (fd_cnt - fd0 !== 2) begin
            errors++;
            $display("FAIL write_read_frame_done: got %0d pulses, required 2", fd_cnt - fd0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] o;
        txq = '{8'h11, 8'h22};
        do_write(24'h000FFF, 2, o);
        do_read(24'h000000, 1, o);
        checks++;
        if (rxq[0] !== 8'h22) begin
            errors++;
            $display("FAIL wrap_write: mem[000] got %h, required 22", rxq[0]);
        end
        do_read(24'h000FFF, 2, o);
        checks++;
        if (rxq[0] !== 8'h11 || rxq[1] !== 8'h22) begin
            errors++;
            $display("FAIL wrap_read: got %h %h, required 11 22", rxq[0], rxq[1]);
        end
    endtask

    task automatic test_partial_write();
        logic [7:0] o;
        logic x;
        int fd0;
        txq = '{8'h5A};
        do_write(24'h000020, 1, o);
        fd0 = fd_cnt;
        spi_begin();
        spi_header(8'h02, 24'h000020, o);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, x);
        spi_end();
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL partial_frame_done: got %0d pulses, required 1", fd_cnt - fd0);
        end
        do_read(24'h000020, 1, o);
        checks++;
        if (rxq[0] !== mdl[32'h20]) begin
            errors++;
            $display("FAIL partial_no_write: mem[020] got %h, required %h", rxq[0], mdl[32'h20]);
        end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] r, o;
        logic x;
        int fd0, ce0;
        fd0 = fd_cnt;
        ce0 = ce_cnt;
        spi_begin();
        spi_byte(8'h05, r);
        o = r;
        clk_n(1);
        checks++;
        if (ce_cnt - ce0 !== 1) begin
            errors++;
            $display("FAIL bad_opcode_after_bit8: cmd_err pulses=%0d, required 1", ce_cnt - ce0);
        end
        for (int i = 0; i < 40; i++) begin
            spi_bit(1'($urandom), x);
            o[0] = o[0] | x;
        end
        spi_end();
        checks++;
        if (ce_cnt - ce0 !== 1 || fd_cnt - fd0 !== 1 || o !== 8'h00) begin
            errors++;
            $display("FAIL bad_opcode_frame: cmd_err=%0d frame_done=%0d sdo_or=%h, required 1 1 00", ce_cnt - ce0, fd_cnt - fd0, o);
        end
        do_read(24'h000010, 2, o);
        checks++;
        if (rxq[0] !== mdl[32'h10] || rxq[1] !== mdl[32'h11]) begin
            errors++;
            $display("FAIL bad_opcode_mem: got %h %h, required %h %h", rxq[0], rxq[1], mdl[32'h10], mdl[32'h11]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] o;
        logic x;
        int fd0;
        spi_begin();
        spi_header(8'h03, 24'h000010, o);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, x);
        sdi = 1'b0;
        clk_n(H);
        sck = 1'b1;  // 36th rise
        clk_n(H);
        fd0 = fd_cnt;
        rst = 1'b1;
        clk_n(1);
        checks++;
        if (sdo !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read_sdo: got %b, required 0", sdo);
        end
        sck = 1'b0;
        clk_n(2);
        rst = 1'b0;
        clk_n(H);
        css = 1'b1;
        clk_n(2 * H);
        checks++;
        if (fd_cnt - fd0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_read_frame_done: got %0d pulses, required 0", fd_cnt - fd0);
        end
        do_read(24'h000010, 1, o);
        checks++;
        if (rxq[0] !== mdl[32'h10]) begin
            errors++;
            $display("FAIL reset_mid_read_after: got %h, required %h", rxq[0], mdl[32'h10]);
        end
    endtask

    task automatic test_upper_addr();
        logic [7:0] o;
        do_read(24'hABC010, 1, o);
        checks++;
        if (rxq[0] !== mdl[32'h10]) begin
            errors++;
            $display("FAIL upper_addr_read: got %h, required %h", rxq[0], mdl[32'h10]);
        end
        txq = '{8'($urandom)};
        do_write(24'hFED030, 1, o);
        do_read(24'h000030, 1, o);
        checks++;
        if (rxq[0] !== mdl[32'h30]) begin
            errors++;
            $display("FAIL upper_addr_write: got %h, required %h", rxq[0], mdl[32'h30]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ow, orr;
        logic [23:0] addr;
        int n, base, fd0;
        for (int it = 0; it < 8; it++) begin
            addr = 24'($urandom);
            if (it == 0) addr[AW-1:0] = '1;  // force a wrapping burst
            n = $urandom_range(1, 6);
            txq.delete();
            for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
            fd0 = fd_cnt;
            do_write(addr, n, ow);
            do_read(addr, n + 1, orr);
            base = int'(addr) % MEMSZ;
            checks++;
            if (ow !== 8'h00 || orr !== 8'h00 || fd_cnt - fd0 !== 2) begin
                errors++;
                $display("FAIL burst_framing it=%0d: wr_sdo_or=%h rd_hdr_sdo_or=%h frame_done=%0d, required 00 00 2", it, ow, orr, fd_cnt - fd0);
            end
            for (int i = 0; i <= n; i++) begin
                if (mvalid[(base + i) % MEMSZ]) begin
                    checks++;
                    if (rxq[i] !== mdl[(base + i) % MEMSZ]) begin
                        errors++;
                        $display("FAIL burst_data it=%0d addr=%h: got %h, required %h", it, (base + i) % MEMSZ, rxq[i], mdl[(base + i) % MEMSZ]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_partial_write();
        test_bad_opcode();
        test_reset_mid_read();
        test_upper_addr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning memory holds 2^ADDR_W bytes and the low ADDR_W bits of the 24-bit command address are used.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sck, css and sdi.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port sck, input, 1, the SPI clock from the controller (mode 0, idle low).
REQ-006 SHALL have port css, input, 1, the active-low chip select from the controller.
REQ-007 SHALL have port sdi, input, 1, controller-to-responder serial data (MOSI).
REQ-008 SHALL have port sdo, output, 1, responder-to-controller serial data (MISO).
REQ-009 SHALL have port frame_done, output, 1, a one-clk pulse on each css deassertion that ends a frame.
REQ-010 SHALL have port cmd_err, output, 1, a one-clk pulse when a received opcode is neither 0x02 nor 0x03.

Function
REQ-011 SHALL pass sck, css and sdi through SYNC_STAGES flops, then detect sck rise/fall and css rise/fall from the synchronized values.
REQ-012 SHALL require sck high and low phases each to last at least SYNC_STAGES+2 clk cycles; no behaviour is required for faster sck.
REQ-013 SHALL implement states IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-014 SHALL move IDLE->CMD on css fall and clear the bit counter.
REQ-015 SHALL sample sdi on every sck rise while css is low; every field is MSB first.
REQ-016 SHALL, in CMD, go to ADDR after the 8th rise if the opcode is 0x02 or 0x03; otherwise it SHALL pulse cmd_err and go to IGNORE.
REQ-017 SHALL, in ADDR, capture 24 bits and load the low ADDR_W bits as the pointer on the 24th rise; the upper bits are discarded.
REQ-018 SHALL, after ADDR, go to WDATA for opcode 0x02 and RDATA for opcode 0x03.
REQ-019 SHALL, in WDATA, write the assembled byte to mem[ptr] on each 8th data rise, then set ptr = (ptr+1) mod 2^ADDR_W.
REQ-020 SHALL, in RDATA, load mem[ptr] into the shift register on the sck fall that follows the address LSB rise, drive its MSB on sdo, and then set ptr = (ptr+1) mod 2^ADDR_W.
REQ-021 SHALL, in RDATA, shift the next bit onto sdo on each subsequent sck fall; on the fall after the 8th bit of a byte it SHALL load the next byte (mem[ptr]) and increment ptr.
REQ-022 SHALL sustain unlimited sequential read or write bursts, with the pointer wrapping from 2^ADDR_W-1 to 0.
REQ-023 SHALL hold sdo at 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
REQ-024 SHALL, on css rise in any non-IDLE state, abort: return to IDLE, discard any partial byte (no write), set sdo to 0 and pulse frame_done once.
REQ-025 SHALL give precedence to css rise over an sck edge detected in the same clk.
REQ-026 SHALL use a byte array for memory with a read latency of at most 1 clk; memory contents SHALL NOT be reset.

Reset
REQ-027 SHALL, while rst is high at posedge clk, force state=IDLE, sdo=0, frame_done=0, cmd_err=0, and clear counters, pointer and synchronizers, regardless of frame progress.
REQ-028 SHALL treat a css that is low at reset release as not a frame start; a new css fall is needed to begin a frame.

Verification
REQ-029 Write frame 02 000010 A5 3C, then read frame 03 000010 with 16 data clocks -> sdo bytes A5 then 3C; frame_done pulses twice.
REQ-030 With ADDR_W=12, write 02 000FFF 11 22, then read 03 000000 -> sdo byte 22; read 03 000FFF -> 11.
REQ-031 Write frame 02 000020 followed by 5 data bits, then css rise -> mem[0x020] unchanged, one frame_done pulse, state returns to IDLE.
REQ-032 Opcode 0x05 followed by 40 more clocks -> one cmd_err pulse after bit 8, sdo stays 0, no memory changes.
REQ-033 rst asserted mid-read after 36 sck rises, css still low -> sdo=0 next clk; after rst release, css rise/fall plus 03 000010 -> returns previously written A5.
REQ-034 Address 0xABC010 with ADDR_W=12 -> accesses byte 0x010; upper address bits are ignored.
